// File: rtl/crc_frame_checker.sv
// Serial CRC frame checker: strips the trailing CRC from each frame, checks the remainder,
// and keeps saturating frame / error statistics.
module crc_frame_checker #(
  parameter int unsigned      DATA_BITS = 1904,
  parameter int unsigned      CRC_W     = 16,
  parameter logic [CRC_W-1:0] POLY      = 16'h1021,
  parameter logic [CRC_W-1:0] INIT      = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ival,
  input  logic             data_in,
  input  logic             isop,
  input  logic             clr_cnt,
  output logic             decod_data,
  output logic             oval_data,
  output logic             osop,
  output logic             oeop,
  output logic             err_val,
  output logic             errors,
  output logic             abort,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned    TOTAL = DATA_BITS + CRC_W;
  localparam int unsigned    BW    = $clog2(TOTAL);
  localparam logic [BW-1:0]  LAST  = BW'(TOTAL - 1);
  localparam logic [BW-1:0]  DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  DBITS = BW'(DATA_BITS);

  typedef enum logic {S_DATA, S_CRC} state_e;

  state_e             state_q, state_d;
  logic [BW-1:0]      cnt_q, cnt_d;
  logic [CRC_W-1:0]   rem_q, rem_d;
  logic               decod_q, decod_d;
  logic               oval_q, oval_d;
  logic               osop_q, osop_d;
  logic               oeop_q, oeop_d;
  logic               err_val_q, err_val_d;
  logic               errors_q, errors_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  // Effective view of the current bit once an isop restart has been applied.
  state_e             eff_state;
  logic [BW-1:0]      eff_cnt;
  logic [CRC_W-1:0]   eff_rem;
  logic [CRC_W-1:0]   rem_upd;
  logic [BW-1:0]      cnt_inc;
  logic               fb;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    decod_d   = 1'b0;
    oval_d    = 1'b0;
    osop_d    = 1'b0;
    oeop_d    = 1'b0;
    err_val_d = 1'b0;
    errors_d  = 1'b0;
    abort_d   = 1'b0;
    eff_state = state_q;
    eff_cnt   = cnt_q;
    eff_rem   = rem_q;
    fb        = 1'b0;
    rem_upd   = rem_q;
    cnt_inc   = cnt_q;
    if (ival) begin
      if (isop) begin
        eff_state = S_DATA;
        eff_cnt   = '0;
        eff_rem   = INIT;
        abort_d   = (cnt_q != '0);
      end
      fb      = eff_rem[CRC_W-1] ^ data_in;
      rem_upd = {eff_rem[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      cnt_inc = eff_cnt + 1'b1;
      if (eff_state == S_DATA) begin
        oval_d  = 1'b1;
        decod_d = data_in;
        osop_d  = (eff_cnt == '0);
        oeop_d  = (eff_cnt == DLAST);
      end
      if (eff_cnt == LAST) begin
        // Remainder including the CRC bits must be zero for a clean frame.
        err_val_d = 1'b1;
        errors_d  = (rem_upd != '0);
        cnt_d     = '0;
        state_d   = S_DATA;
        rem_d     = INIT;
      end else begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc < DBITS) ? S_DATA : S_CRC;
        rem_d   = rem_upd;
      end
    end
  end

  // Statistics: clear wins over a same-edge increment; both saturate.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (clr_cnt) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else if (err_val_d) begin
      if (frame_cnt_q != '1)            frame_cnt_d = frame_cnt_q + 1'b1;
      if (errors_d && err_cnt_q != '1)  err_cnt_d   = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_DATA;
      cnt_q       <= '0;
      rem_q       <= INIT;
      decod_q     <= 1'b0;
      oval_q      <= 1'b0;
      osop_q      <= 1'b0;
      oeop_q      <= 1'b0;
      err_val_q   <= 1'b0;
      errors_q    <= 1'b0;
      abort_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      decod_q     <= decod_d;
      oval_q      <= oval_d;
      osop_q      <= osop_d;
      oeop_q      <= oeop_d;
      err_val_q   <= err_val_d;
      errors_q    <= errors_d;
      abort_q     <= abort_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign decod_data = decod_q;
  assign oval_data  = oval_q;
  assign osop       = osop_q;
  assign oeop       = oeop_q;
  assign err_val    = err_val_q;
  assign errors     = errors_q;
  assign abort      = abort_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/crc_frame_checker.md
CRC_FRAME_CHECKER -- requirements
Module: crc_frame_checker

Interface
REQ-001 Parameter DATA_BITS, default 1904: payload bits per frame, range 1..65535.
REQ-002 Parameter CRC_W, default 16: CRC width, range 8..32.
REQ-003 Parameter POLY, default 16'h1021: generator polynomial, implicit x^CRC_W term omitted.
REQ-004 Parameter INIT, default 0: remainder register preset value at frame start.
REQ-005 Parameter CNT_W, default 16: width of the frame and error statistics counters.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 ival  input  1  input bit valid; all state advances only on cycles with ival=1.
REQ-009 data_in  input  1  serial frame bit, MSB first: DATA_BITS payload bits, then CRC_W CRC bits.
REQ-010 isop  input  1  frame-start marker, qualified by ival.
REQ-011 clr_cnt  input  1  synchronous clear of the statistics counters.
REQ-012 decod_data  output  1  payload bit; forced to 0 when oval_data=0.
REQ-013 oval_data  output  1  payload bit valid.
REQ-014 osop / oeop  output  1 each  first / last payload bit marker, aligned with oval_data.
REQ-015 err_val  output  1  one-cycle frame-check-complete strobe.
REQ-016 errors  output  1  CRC mismatch flag, valid only with err_val, otherwise 0.
REQ-017 abort  output  1  one-cycle strobe: frame truncated by isop.
REQ-018 frame_cnt / err_cnt  output  CNT_W each  checked frames / failed frames.

Function
REQ-019 Bit counter SHALL run 0..DATA_BITS+CRC_W-1, advance by 1 per accepted bit (ival=1), and wrap to 0 after the last CRC bit.
REQ-020 Two states SHALL exist: S_DATA (counter < DATA_BITS) and S_CRC (all other counts); S_DATA goes to S_CRC after payload bit DATA_BITS-1, and S_CRC goes to S_DATA after the last CRC bit.
REQ-021 Per accepted bit: fb = rem[CRC_W-1] XOR data_in; rem <= (rem<<1) XOR (fb ? POLY : 0); computed over payload and CRC bits.
REQ-022 rem SHALL load INIT at reset and after each frame's last CRC bit.
REQ-023 Frame passes iff the rem value after the last CRC bit is 0.
REQ-024 All outputs SHALL be registered, with a latency of exactly 1 clk after the accepted bit.
REQ-025 oval_data=1 for each accepted payload bit; osop at count 0; oeop at count DATA_BITS-1; if DATA_BITS=1, osop and oeop are both 1.
REQ-026 CRC bits SHALL NOT appear on decod_data.
REQ-027 err_val=1 for 1 cycle after the last CRC bit is accepted; errors is driven in the same cycle.
REQ-028 ival=0 cycles SHALL hold all state; strobe outputs go to 0.
REQ-029 ival=1 with isop=1 SHALL treat the bit as count 0 of a new frame: rem restarts from INIT, then absorbs the bit.
REQ-030 If that isop bit arrives with the counter at nonzero, abort SHALL pulse, the truncated frame produces no err_val, and both counters are unaffected.
REQ-031 isop at count 0 SHALL be a no-op.
REQ-032 isop with ival=0 SHALL be ignored.
REQ-033 On err_val, frame_cnt SHALL increment by 1; err_cnt SHALL increment when errors=1; both saturate at 2^CNT_W-1 and never wrap.
REQ-034 clr_cnt SHALL zero both counters on the next edge and take priority over a simultaneous increment.

Reset
REQ-035 When rst is low, counter=0, state=S_DATA, rem=INIT, all 1-bit outputs 0, frame_cnt=err_cnt=0.
REQ-036 A reset mid-frame SHALL discard the partial frame with no err_val and no abort.
REQ-037 After reset release, the first accepted bit is count 0.

Verification (DATA_BITS=8, CRC_W=16, POLY=16'h1021, INIT=0, CNT_W=4)
REQ-038 Stream 0x01 then 0x1021, ival=1 continuously -> 8 oval_data pulses, osop on the 1st and oeop on the 8th, err_val on cycle 25 with errors=0, frame_cnt=1, err_cnt=0.
REQ-039 Same frame with the payload LSB flipped -> err_val with errors=1, err_cnt=1.
REQ-040 Same frame with ival toggling 1/0 -> identical output sequence, stretched; no strobe on any ival=0 cycle.
REQ-041 isop at count 12, followed by a good frame -> abort pulse, then exactly one err_val (errors=0), frame_cnt=1.
REQ-042 Send 17 bad frames, then assert clr_cnt on the same edge as the 18th err_val -> err_cnt saturates at 15; after the clr_cnt edge, both counters=0.
REQ-043 rst low at count 20, then a good frame -> no err_val for the partial frame; the good frame passes with frame_cnt=1.
